fmap_unpacker: RTL
==================

Name: fmap_unpacker

Overview:
- Reader side of the wide flat feature-map bus that the conv/BN/SiLU stage produces (completion pulse plus K*OH*OW FP16 words).
- On the completion pulse it snapshots the whole bus. It then streams the words out one per handshake with valid/ready, and tags each word with channel, row and column indices.
- It sits between a CBS-style stage and any word-serial consumer (next-layer loader, DMA, debug tap).

Parameters:
- K, 13, number of channels (filters) in the bus
- OH, 30, output feature-map height
- OW, 30, output feature-map width
- DATA_WIDTH, 16 (localparam, fixed), FP16 word width
- CW/RW/XW (localparams), clog2 of K/OH/OW, minimum 1 each

Ports:
- clk  input  1  clock; all state changes on rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset)
- in_valid  input  1  frame-complete strobe from producer; level or pulse
- in_data  input  [0:K*OH*OW*16-1]  flat frame; word i at bits [16*i : 16*i+15], i = k*OH*OW + r*OW + c
- in_ready  output  1  high when idle and able to capture a frame
- out_valid  output  1  out_data and index outputs hold a valid word
- out_ready  input  1  consumer accepts the word when high with out_valid
- out_data  output  [15:0]  FP16 word
- out_ch  output  CW  channel index k
- out_row  output  RW  row index r
- out_col  output  XW  column index c
- out_last  output  1  high with the final word, where k=K-1, r=OH-1, c=OW-1
- busy  output  1  high while in STREAM

Behaviour:
- Reset (reset=0, asynchronous):
  - state IDLE; snapshot discarded
  - out_valid=0, out_data=0, out_ch/out_row/out_col=0, out_last=0, busy=0, in_ready=1
- States: IDLE and STREAM.
- IDLE:
  - in_ready=1.
  - At an edge with in_valid=1, the block loads the snapshot from in_data and moves to STREAM.
  - On the same edge it sets out_valid=1 and presents word 0 with indices 0,0,0.
  - Latency is one edge from accept to the first valid word.
- STREAM:
  - in_ready=0; in_valid is ignored with no queueing.
  - A handshake is out_valid and out_ready both high at an edge.
  - On a handshake the block advances to the next word. col increments; at OW-1 it wraps to 0 and row increments. row wraps at OH-1 and ch increments.
  - With out_ready=0, out_valid, out_data, the indices and out_last are held stable.
  - On the handshake where out_last=1, the block returns to IDLE and drops out_valid and out_last in the same edge. in_ready rises on the next cycle.
  - An accept cannot occur in the same cycle as the last handshake. The minimum frame-to-frame gap is 1 idle cycle.
- Total: K*OH*OW handshakes per frame, exactly once each, in index order.
- Degenerate sizes: if K*OH*OW = 1, word 0 is presented with out_last=1 immediately.
- Reset mid-STREAM aborts the frame. After release the block is in IDLE with no residual words.
- Snapshot storage is a shift register or an indexed mux (implementer's choice); only the port behaviour is specified.
- The producer must hold in_data stable on the accept edge only. Later changes have no effect.

Optional Feature:
- Macro: FMAP_NAN_FLUSH_EN
- Defined:
  - Any output word with exponent 5'b11111 (Inf/NaN) is emitted as 16'h0000.
  - A sticky output nan_flag (1 bit) sets on any flushed word. It clears on reset and on each new frame accept.
- Undefined: words pass through bit-exact and the nan_flag port does not exist.

Decomposition:
- Shared package fmap_pkg holds:
  - DATA_WIDTH=16
  - FP16_EXP_MASK=16'h7C00
  - state enum {IDLE, STREAM}
  - clog2 helper with minimum-1 clamp
- One natural sub-module, fmap_index_counter: nested ch/row/col counter with an advance input, a last output and a clear input.

Test Plan:
- K=2,OH=2,OW=2; frame words 16'h3C00..16'h3C07; out_ready=1 always -> 8 words in order on consecutive cycles; indices (0,0,0)..(1,1,1); out_last only on word 16'h3C07; in_ready returns 1 one cycle later.
- Same frame; out_ready toggling 1,0,0,1 repeating -> every word held stable while stalled; no duplicates or drops; 8 handshakes total.
- in_valid pulsed again mid-STREAM with different data -> ignored; current frame completes unchanged; in_ready stays 0 until after out_last.
- reset=0 asserted after 3 handshakes -> outputs immediately return to their reset values; a new frame after release streams from word 0 with indices 0.
- Back-to-back frames with in_valid held high -> second accept occurs exactly 1 cycle after the last handshake of the first frame; its first word is that frame's word 0.
- FMAP_NAN_FLUSH_EN defined; word 3=16'h7E00, word 5=16'h7C00 -> both emitted as 16'h0000; nan_flag=1 from word 3 onward; nan_flag clears on next accept.

Source files
------------

// File: rtl/fmap_pkg.sv
// Shared constants, FSM state type and sizing helpers for the feature-map unpacker.
package fmap_pkg;

    localparam int DATA_WIDTH = 16;
    localparam logic [DATA_WIDTH-1:0] FP16_EXP_MASK = 16'h7C00;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_e;

    // Index widths never collapse to zero bits, even for a dimension of 1.
    function automatic int clog2_min1(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    function automatic logic fp16_nonfinite(input logic [DATA_WIDTH-1:0] w);
        return (w & FP16_EXP_MASK) == FP16_EXP_MASK;
    endfunction

endpackage

// File: rtl/fmap_index_counter.sv
// Nested channel/row/column counter; column is the fastest-moving index.
module fmap_index_counter
    import fmap_pkg::*;
#(
    parameter int K  = 13,
    parameter int OH = 30,
    parameter int OW = 30,
    localparam int CW = clog2_min1(K),
    localparam int RW = clog2_min1(OH),
    localparam int XW = clog2_min1(OW)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear_i,
    input  logic          advance_i,
    output logic [CW-1:0] ch_o,
    output logic [RW-1:0] row_o,
    output logic [XW-1:0] col_o,
    output logic          last_o
);

    logic [CW-1:0] ch_q, ch_d;
    logic [RW-1:0] row_q, row_d;
    logic [XW-1:0] col_q, col_d;
    logic          col_wrap, row_wrap, ch_wrap;

    assign col_wrap = (col_q == XW'(OW - 1));
    assign row_wrap = (row_q == RW'(OH - 1));
    assign ch_wrap  = (ch_q  == CW'(K - 1));

    always_comb begin
        ch_d  = ch_q;
        row_d = row_q;
        col_d = col_q;
        if (clear_i) begin
            ch_d  = '0;
            row_d = '0;
            col_d = '0;
        end else if (advance_i) begin
            if (col_wrap) begin
                col_d = '0;
                if (row_wrap) begin
                    row_d = '0;
                    ch_d  = ch_wrap ? '0 : ch_q + CW'(1);
                end else begin
                    row_d = row_q + RW'(1);
                end
            end else begin
                col_d = col_q + XW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ch_q  <= '0;
            row_q <= '0;
            col_q <= '0;
        end else begin
            ch_q  <= ch_d;
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign ch_o   = ch_q;
    assign row_o  = row_q;
    assign col_o  = col_q;
    assign last_o = col_wrap && row_wrap && ch_wrap;

endmodule

// File: rtl/fmap_unpacker.sv
// Snapshots a flat K*OH*OW FP16 feature-map bus and streams it word by word with indices.
// Build option FMAP_NAN_FLUSH_EN: zero Inf/NaN words on output and raise a sticky nan_flag.
module fmap_unpacker
    import fmap_pkg::*;
#(
    parameter int K  = 13,
    parameter int OH = 30,
    parameter int OW = 30,
    localparam int CW = clog2_min1(K),
    localparam int RW = clog2_min1(OH),
    localparam int XW = clog2_min1(OW),
    localparam int N  = K * OH * OW,
    localparam int LW = clog2_min1(N)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [0:N*DATA_WIDTH-1] in_data,
    output logic                    in_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic [CW-1:0]           out_ch,
    output logic [RW-1:0]           out_row,
    output logic [XW-1:0]           out_col,
    output logic                    out_last,
    output logic                    busy
`ifdef FMAP_NAN_FLUSH_EN
    ,
    output logic                    nan_flag
`endif
);

    state_e                state_q;
    logic [LW-1:0]         lin_q, lin_nxt;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [DATA_WIDTH-1:0] in_words [N];
    logic [DATA_WIDTH-1:0] snap_q   [N];
    logic [DATA_WIDTH-1:0] raw_d, word_d;
    logic                  accept, handshake, last_pos;

    for (genvar gi = 0; gi < N; gi++) begin : g_words
        assign in_words[gi] = in_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    assign accept    = (state_q == IDLE) && in_valid;
    assign handshake = (state_q == STREAM) && out_ready;
    assign lin_nxt   = last_pos ? '0 : lin_q + LW'(1);

    // Data-only storage: no reset needed, out_valid gates any stale contents.
    always_ff @(posedge clk) begin
        if (accept) begin
            snap_q <= in_words;
        end
    end

    // Word 0 bypasses the snapshot so it is presented on the accept edge itself.
    always_comb begin
        raw_d = accept ? in_words[0] : snap_q[lin_nxt];
`ifdef FMAP_NAN_FLUSH_EN
        word_d = fp16_nonfinite(raw_d) ? '0 : raw_d;
`else
        word_d = raw_d;
`endif
    end

`ifdef FMAP_NAN_FLUSH_EN
    logic nan_flag_q;
    assign nan_flag = nan_flag_q;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            lin_q      <= '0;
            out_data_q <= '0;
`ifdef FMAP_NAN_FLUSH_EN
            nan_flag_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        state_q    <= STREAM;
                        lin_q      <= '0;
                        out_data_q <= word_d;
`ifdef FMAP_NAN_FLUSH_EN
                        nan_flag_q <= fp16_nonfinite(raw_d);
`endif
                    end
                end
                STREAM: begin
                    if (out_ready) begin
                        if (last_pos) begin
                            state_q <= IDLE;
                        end else begin
                            lin_q      <= lin_nxt;
                            out_data_q <= word_d;
`ifdef FMAP_NAN_FLUSH_EN
                            nan_flag_q <= nan_flag_q | fp16_nonfinite(raw_d);
`endif
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    fmap_index_counter #(
        .K  (K),
        .OH (OH),
        .OW (OW)
    ) u_idx (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (accept),
        .advance_i (handshake),
        .ch_o      (out_ch),
        .row_o     (out_row),
        .col_o     (out_col),
        .last_o    (last_pos)
    );

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == STREAM);
    assign out_valid = (state_q == STREAM);
    assign out_last  = last_pos && (state_q == STREAM);
    assign out_data  = out_data_q;

endmodule
